issue_select: RTL and testbench

- Oldest-first select/scheduler for the 8-entry issue queue.
- Tracks relative age of occupied slots with an age matrix.
- Each cycle picks up to two ready slots and drives the queue's pop0/pop_key0 and pop1/pop_key1.
- Sits between wakeup logic, which supplies per-slot ready bits, and the two functional-unit issue ports.

---
 rtl/issue_select_pkg.sv | 27 ++
 rtl/issue_select_age_pick.sv | 43 ++++
 rtl/issue_select.sv | 150 +++++++++++++++
 tb/tb_issue_select.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/issue_select_pkg.sv
// ============================================================================
// Module   : issue_select_pkg
// Brief    : Shared sizing, types and helpers for the issue_select scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package issue_select_pkg;

    localparam int NUM_IQ_ENTRIES      = 8;
    localparam int NUM_IQ_ENTRIES_LOG2 = 3;

    typedef logic [NUM_IQ_ENTRIES-1:0]                     slot_mask_t;
    typedef logic [NUM_IQ_ENTRIES_LOG2-1:0]                slot_idx_t;
    // age[i][j] = 1 : slot i is older than slot j
    typedef logic [NUM_IQ_ENTRIES-1:0][NUM_IQ_ENTRIES-1:0] age_mat_t;

    function automatic slot_mask_t slot_onehot(input slot_idx_t idx);
        slot_mask_t m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/issue_select_age_pick.sv
// ============================================================================
// Module   : issue_select_age_pick
// Brief    : Combinational oldest-candidate finder over an age matrix.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_select_age_pick
    import issue_select_pkg::*;
(
    input  slot_mask_t cand_i,
    input  age_mat_t   age_i,
    output logic       found_o,
    output slot_idx_t  idx_o
);

    slot_mask_t w_oldest;

    // A candidate is oldest when no other candidate claims to be older than it.
    for (genvar gi = 0; gi < NUM_IQ_ENTRIES; gi++) begin : g_oldest
        always_comb begin
            w_oldest[gi] = cand_i[gi];
            for (int j = 0; j < NUM_IQ_ENTRIES; j++) begin
                if (cand_i[j] && age_i[j][gi]) begin
                    w_oldest[gi] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        found_o = |w_oldest;
        idx_o   = '0;
        for (int i = NUM_IQ_ENTRIES - 1; i >= 0; i--) begin
            if (w_oldest[i]) begin
                idx_o = slot_idx_t'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/issue_select.sv
// ============================================================================
// Module   : issue_select
// Brief    : Oldest-first dual-issue select for the 8-entry issue queue.
//            Optional counters enabled by defining ISSUE_SELECT_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_select
    import issue_select_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [NUM_IQ_ENTRIES-1:0]      slot_vld,
    input  logic [NUM_IQ_ENTRIES-1:0]      slot_rdy,
    input  logic                           alloc0,
    input  logic [NUM_IQ_ENTRIES_LOG2-1:0] alloc_key0,
    input  logic                           alloc1,
    input  logic [NUM_IQ_ENTRIES_LOG2-1:0] alloc_key1,
    input  logic                           fu0_ready,
    input  logic                           fu1_ready,
    output logic                           pop0,
    output logic [NUM_IQ_ENTRIES_LOG2-1:0] pop_key0,
    output logic                           pop1,
    output logic [NUM_IQ_ENTRIES_LOG2-1:0] pop_key1
`ifdef ISSUE_SELECT_STATS_EN
    ,
    output logic [31:0]                    issued_cnt,
    output logic [31:0]                    stall_cnt
`endif
);

    age_mat_t   age_q, age_d;
    slot_mask_t inflight_q, inflight_d;
    logic       pop0_q, pop0_d, pop1_q, pop1_d;
    slot_idx_t  key0_q, key0_d, key1_q, key1_d;

    slot_mask_t w_cand, w_cand_rest;
    logic       w_found0, w_found1;
    slot_idx_t  w_idx0, w_idx1;

    // Slots already on the pop outputs still show vld this cycle; mask them.
    assign w_cand      = slot_vld & slot_rdy & ~inflight_q;
    assign w_cand_rest = w_cand & ~(w_found0 ? slot_onehot(w_idx0) : '0);

    issue_select_age_pick u_pick_first (
        .cand_i  (w_cand),
        .age_i   (age_q),
        .found_o (w_found0),
        .idx_o   (w_idx0)
    );

    issue_select_age_pick u_pick_second (
        .cand_i  (w_cand_rest),
        .age_i   (age_q),
        .found_o (w_found1),
        .idx_o   (w_idx1)
    );

    always_comb begin
        pop0_d = 1'b0;
        pop1_d = 1'b0;
        key0_d = key0_q;
        key1_d = key1_q;
        if (!flush) begin
            if (fu0_ready) begin
                pop0_d = w_found0;
                if (w_found0) key0_d = w_idx0;
                if (fu1_ready) begin
                    pop1_d = w_found1;
                    if (w_found1) key1_d = w_idx1;
                end
            end else if (fu1_ready) begin
                pop1_d = w_found0;
                if (w_found0) key1_d = w_idx0;
            end
        end
        inflight_d = (pop0_d ? slot_onehot(key0_d) : '0)
                   | (pop1_d ? slot_onehot(key1_d) : '0);
    end

    // Newly allocated slots become youngest; alloc1 is younger than alloc0.
    always_comb begin
        age_d = age_q;
        if (flush) begin
            age_d = '0;
        end else begin
            for (int i = 0; i < NUM_IQ_ENTRIES; i++) begin
                for (int j = 0; j < NUM_IQ_ENTRIES; j++) begin
                    if (alloc1 && slot_idx_t'(i) == alloc_key1) begin
                        age_d[i][j] = 1'b0;
                    end else if (alloc1 && slot_idx_t'(j) == alloc_key1 &&
                                 (slot_vld[i] || (alloc0 && slot_idx_t'(i) == alloc_key0))) begin
                        age_d[i][j] = 1'b1;
                    end else if (alloc0 && slot_idx_t'(i) == alloc_key0) begin
                        age_d[i][j] = 1'b0;
                    end else if (alloc0 && slot_idx_t'(j) == alloc_key0 && slot_vld[i]) begin
                        age_d[i][j] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age_q      <= '0;
            inflight_q <= '0;
            pop0_q     <= 1'b0;
            pop1_q     <= 1'b0;
            key0_q     <= '0;
            key1_q     <= '0;
        end else begin
            age_q      <= age_d;
            inflight_q <= inflight_d;
            pop0_q     <= pop0_d;
            pop1_q     <= pop1_d;
            key0_q     <= key0_d;
            key1_q     <= key1_d;
        end
    end

    assign pop0     = pop0_q;
    assign pop1     = pop1_q;
    assign pop_key0 = key0_q;
    assign pop_key1 = key1_q;

`ifdef ISSUE_SELECT_STATS_EN
    logic [31:0] issued_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            issued_cnt_q <= issued_cnt_q + 32'(pop0_d) + 32'(pop1_d);
            if ((|w_cand) && !pop0_d && !pop1_d) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign issued_cnt = issued_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_issue_select.sv
// ============================================================================
// Module   : tb_issue_select
// Brief    : Scoreboard bench for issue_select with a simple issue-queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_select;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [7:0] slot_vld;
    logic [7:0] slot_rdy;
    logic       alloc0, alloc1;
    logic [2:0] alloc_key0, alloc_key1;
    logic       fu0_ready, fu1_ready;
    logic       pop0, pop1;
    logic [2:0] pop_key0, pop_key1;
`ifdef ISSUE_SELECT_STATS_EN
    logic [31:0] issued_cnt, stall_cnt;
`endif

    issue_select u_dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .slot_vld   (slot_vld),
        .slot_rdy   (slot_rdy),
        .alloc0     (alloc0),
        .alloc_key0 (alloc_key0),
        .alloc1     (alloc1),
        .alloc_key1 (alloc_key1),
        .fu0_ready  (fu0_ready),
        .fu1_ready  (fu1_ready),
        .pop0       (pop0),
        .pop_key0   (pop_key0),
        .pop1       (pop1),
        .pop_key1   (pop_key1)
`ifdef ISSUE_SELECT_STATS_EN
        ,
        .issued_cnt (issued_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       p0;
        logic [2:0] k0;
        logic       p1;
        logic [2:0] k1;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] prev_pop_mask = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, act, exp);
        end
    endtask

    // One clock: push expectation, model the queue's vld update, compare outputs.
    task automatic tick(input logic p0, input logic [2:0] k0, input logic p1, input logic [2:0] k1);
        exp_t       e;
        exp_t       g;
        logic [7:0] amask;
        logic       fl;
        e.p0 = p0; e.k0 = k0; e.p1 = p1; e.k1 = k1;
        sb.push_back(e);
        amask = '0;
        if (alloc0) amask[alloc_key0] = 1'b1;
        if (alloc1) amask[alloc_key1] = 1'b1;
        fl = flush;
        @(posedge clk);
        #1;
        slot_vld = fl ? 8'h00 : ((slot_vld & ~prev_pop_mask) | amask);
        g = sb.pop_front();
        chk("pop0", {31'b0, pop0}, {31'b0, g.p0});
        if (g.p0) chk("pop_key0", {29'b0, pop_key0}, {29'b0, g.k0});
        chk("pop1", {31'b0, pop1}, {31'b0, g.p1});
        if (g.p1) chk("pop_key1", {29'b0, pop_key1}, {29'b0, g.k1});
        prev_pop_mask = '0;
        if (g.p0) prev_pop_mask[g.k0] = 1'b1;
        if (g.p1) prev_pop_mask[g.k1] = 1'b1;
        alloc0 = 1'b0;
        alloc1 = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic do_alloc(input logic a0, input logic [2:0] k0, input logic a1, input logic [2:0] k1);
        alloc0 = a0; alloc_key0 = k0;
        alloc1 = a1; alloc_key1 = k1;
    endtask

    task automatic idle();
        tick(1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        slot_vld = '0; slot_rdy = '0;
        alloc0 = 1'b0; alloc1 = 1'b0; alloc_key0 = '0; alloc_key1 = '0;
        fu0_ready = 1'b1; fu1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pop0", {31'b0, pop0}, 32'd0);
        chk("rst_pop1", {31'b0, pop1}, 32'd0);
        chk("rst_key0", {29'b0, pop_key0}, 32'd0);
        chk("rst_key1", {29'b0, pop_key1}, 32'd0);
        reset = 1'b0;

        // Successive allocs 3, 5, 1, then all ready
        do_alloc(1'b1, 3'd3, 1'b0, 3'd0); idle();
        do_alloc(1'b1, 3'd5, 1'b0, 3'd0); idle();
        do_alloc(1'b1, 3'd1, 1'b0, 3'd0); idle();
        slot_rdy = 8'hFF;
        tick(1'b1, 3'd3, 1'b1, 3'd5);
        tick(1'b1, 3'd1, 1'b0, 3'd0);
        idle();

        // Same-cycle pair: alloc0 older than alloc1
        do_alloc(1'b1, 3'd6, 1'b1, 3'd2); idle();
        tick(1'b1, 3'd6, 1'b1, 3'd2);
        idle();
        idle();

        // Only port 1 ready; slot must not reissue while inflight
        do_alloc(1'b1, 3'd4, 1'b0, 3'd0); idle();
        fu0_ready = 1'b0;
        tick(1'b0, 3'd0, 1'b1, 3'd4);
        idle();
        idle();
        fu0_ready = 1'b1;

        // Fill all slots, only youngest ready first, then drain oldest-first
        slot_rdy = 8'h00;
        do_alloc(1'b1, 3'd0, 1'b1, 3'd1); idle();
        do_alloc(1'b1, 3'd2, 1'b1, 3'd3); idle();
        do_alloc(1'b1, 3'd4, 1'b1, 3'd5); idle();
        do_alloc(1'b1, 3'd6, 1'b1, 3'd7); idle();
        chk("vld_full", {24'b0, slot_vld}, 32'hFF);
        slot_rdy = 8'h80;
        tick(1'b1, 3'd7, 1'b0, 3'd0);
        slot_rdy = 8'h00;
        idle();
        slot_rdy = 8'hFF;
        tick(1'b1, 3'd0, 1'b1, 3'd1);
        tick(1'b1, 3'd2, 1'b1, 3'd3);
        tick(1'b1, 3'd4, 1'b1, 3'd5);
        tick(1'b1, 3'd6, 1'b0, 3'd0);
        idle();

        // Asynchronous reset while pop0 is high
        do_alloc(1'b1, 3'd3, 1'b0, 3'd0); idle();
        tick(1'b1, 3'd3, 1'b0, 3'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_pop0", {31'b0, pop0}, 32'd0);
        chk("async_rst_pop1", {31'b0, pop1}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        slot_vld = '0;
        prev_pop_mask = '0;
        idle();
        idle();

        // Flush with three ready entries
        slot_rdy = 8'h00;
        do_alloc(1'b1, 3'd1, 1'b1, 3'd2); idle();
        do_alloc(1'b1, 3'd5, 1'b0, 3'd0); idle();
        slot_rdy = 8'hFF;
        flush = 1'b1;
        idle();
        idle();
        do_alloc(1'b1, 3'd2, 1'b0, 3'd0); idle();
        tick(1'b1, 3'd2, 1'b0, 3'd0);
        idle();

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
